// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle for uart_tx.
// The master side drives a byte plus its frame configuration, and the slave
// side (the transmitter) returns the serial line and its busy flag.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] p_data_i;
    logic                  data_valid_i;
    logic                  parity_enable_i;
    logic                  parity_type_i;
    logic [5:0]            prescale_i;
    logic                  tx_out_o;
    logic                  busy_o;

    modport master (
        output p_data_i,
        output data_valid_i,
        output parity_enable_i,
        output parity_type_i,
        output prescale_i,
        input  tx_out_o,
        input  busy_o
    );

    modport slave (
        input  p_data_i,
        input  data_valid_i,
        input  parity_enable_i,
        input  parity_type_i,
        input  prescale_i,
        output tx_out_o,
        output busy_o
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, stop bit. Each bit is held for Prescale clock cycles.
// Optional feature macro: UART_TX_TWO_STOP_EN (two stop bits when defined).
// The byte and its configuration are captured into shadow registers when a
// request is accepted, so the input bus may change freely mid-frame.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  pen_q, pen_d;
    logic [5:0]            pre_q, pre_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_end;

    // Last cycle of the current bit period; the shadow prescale is never 0.
    assign bit_end = (cnt_q == (pre_q - 6'd1));

    assign bus.tx_out_o = tx_q;
    assign bus.busy_o   = busy_q;

    // State, counters, shadow registers and the registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            idx_q   <= 4'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            pre_q   <= 6'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            pre_q   <= pre_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; the line level for each bit is decided one edge early
    // so TX_OUT and busy change on the very edge that starts the bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        pen_d   = pen_q;
        pre_d   = pre_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.data_valid_i && !busy_q) begin
                    state_d = START;
                    cnt_d   = 6'd0;
                    idx_d   = 4'd0;
                    shift_d = bus.p_data_i;
                    par_d   = (^bus.p_data_i) ^ bus.parity_type_i;
                    pen_d   = bus.parity_enable_i;
                    pre_d   = (bus.prescale_i == 6'd0) ? 6'd1 : bus.prescale_i;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = 6'd0;
                    idx_d   = 4'd0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = 6'd0;
                    if (idx_q == LAST_IDX) begin
                        idx_d = 4'd0;
                        if (pen_q) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = 6'd0;
                    idx_d   = 4'd0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    cnt_d = 6'd0;
`ifdef UART_TX_TWO_STOP_EN
                    if (idx_q == 4'd0) begin
                        idx_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = IDLE;
                    idx_d   = 4'd0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
                idx_d   = 4'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx.
// A frame-level model expands each accepted request into the per-cycle line
// levels it must produce, and a compare process checks TX_OUT and busy against
// it on every falling edge. Directed scenarios add literal expectations.
module tb_uart_tx;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOPS   = 2;
    localparam int B8N1    = 88;
    localparam int B8E1    = 96;
    localparam int B4N1    = 44;
    localparam int B1N1    = 11;
    localparam int STOP8   = 16;
`else
    localparam int STOPS   = 1;
    localparam int B8N1    = 80;
    localparam int B8E1    = 88;
    localparam int B4N1    = 40;
    localparam int B1N1    = 10;
    localparam int STOP8   = 8;
`endif

    logic clk = 1'b0;
    logic rst_n;

    int passCount  = 0;
    int checkCount = 0;
    bit cmpEn      = 1'b0;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and reports it when it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame model: on acceptance, queue every line level of the frame.
    logic expQ[$];
    logic expTx   = 1'b1;
    logic expBusy = 1'b0;
    logic frameBits[$];
    int   modelPre;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
            expTx   = 1'b1;
            expBusy = 1'b0;
        end else begin
            if (!expBusy && bus.data_valid_i === 1'b1) begin
                modelPre = (bus.prescale_i == 6'd0) ? 1 : int'(bus.prescale_i);
                frameBits.delete();
                frameBits.push_back(1'b0);
                for (int i = 0; i < 8; i++) frameBits.push_back(bus.p_data_i[i]);
                if (bus.parity_enable_i) frameBits.push_back((^bus.p_data_i) ^ bus.parity_type_i);
                for (int s = 0; s < STOPS; s++) frameBits.push_back(1'b1);
                foreach (frameBits[b]) begin
                    for (int r = 0; r < modelPre; r++) expQ.push_back(frameBits[b]);
                end
            end
            if (expQ.size() > 0) begin
                expTx   = expQ.pop_front();
                expBusy = 1'b1;
            end else begin
                expTx   = 1'b1;
                expBusy = 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("txLine", bus.tx_out_o, expTx);
            checkOutput("busyFlag", bus.busy_o, expBusy);
        end
    end

    // Drives one request for a single clock, leaving the inputs untouched after.
    task automatic applyStimulus(input logic [7:0] data, input logic pe, input logic pt, input logic [5:0] pre);
        bus.p_data_i        = data;
        bus.parity_enable_i = pe;
        bus.parity_type_i   = pt;
        bus.prescale_i      = pre;
        bus.data_valid_i    = 1'b1;
        @(negedge clk);
        bus.data_valid_i    = 1'b0;
    endtask

    // Records a whole frame and decodes it by sampling the middle of each bit.
    task automatic measureFrame(input int pre, input bit pe, output int busyCycles,
                                output logic [7:0] dataByte, output logic startBit,
                                output logic parBit, output int stopHigh);
        logic txLog[$];
        int   waitCnt;
        int   p;
        int   idx;
        int   firstStop;
        p = (pre == 0) ? 1 : pre;
        waitCnt = 0;
        while (bus.busy_o !== 1'b1 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("busyRise", bus.busy_o, 1'b1);
        busyCycles = 0;
        while (bus.busy_o === 1'b1 && busyCycles < 2000) begin
            txLog.push_back(bus.tx_out_o);
            busyCycles++;
            @(negedge clk);
        end
        startBit = (p / 2 < txLog.size()) ? txLog[p/2] : 1'bx;
        for (int j = 0; j < 8; j++) begin
            idx = (1 + j) * p + p / 2;
            dataByte[j] = (idx < txLog.size()) ? txLog[idx] : 1'bx;
        end
        idx = 9 * p + p / 2;
        parBit = (pe && idx < txLog.size()) ? txLog[idx] : 1'b0;
        firstStop = (9 + (pe ? 1 : 0)) * p;
        stopHigh = 0;
        for (int k = firstStop; k < txLog.size(); k++) begin
            if (txLog[k] === 1'b1) stopHigh++;
        end
    endtask

    // Aborts a run that never finishes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int         busyCycles;
        logic [7:0] dataByte;
        logic       startBit;
        logic       parBit;
        int         stopHigh;
        int         cnt;
        int         gap;

        rst_n               = 1'b0;
        bus.p_data_i        = 8'h00;
        bus.data_valid_i    = 1'b0;
        bus.parity_enable_i = 1'b0;
        bus.parity_type_i   = 1'b0;
        bus.prescale_i      = 6'd8;
        repeat (3) @(negedge clk);
        cmpEn = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("resetTx", bus.tx_out_o, 1'b1);
        checkOutput("resetBusy", bus.busy_o, 1'b0);

        $display("[TB] 8N1 0xA5 at prescale 8");
        applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8);
        measureFrame(8, 1'b0, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("8n1Busy", busyCycles, B8N1);
        checkOutput("8n1Start", startBit, 1'b0);
        checkOutput("8n1Data", dataByte, 8'hA5);
        checkOutput("8n1StopLen", stopHigh, STOP8);
        repeat (3) @(negedge clk);

        $display("[TB] parity frames");
        applyStimulus(8'hA5, 1'b1, 1'b0, 6'd8);
        measureFrame(8, 1'b1, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("evenA5Busy", busyCycles, B8E1);
        checkOutput("evenA5Par", parBit, 1'b0);
        checkOutput("evenA5Data", dataByte, 8'hA5);
        repeat (2) @(negedge clk);
        applyStimulus(8'hA5, 1'b1, 1'b1, 6'd8);
        measureFrame(8, 1'b1, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("oddA5Par", parBit, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(8'h07, 1'b1, 1'b0, 6'd8);
        measureFrame(8, 1'b1, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("even07Par", parBit, 1'b1);
        checkOutput("even07Data", dataByte, 8'h07);
        repeat (3) @(negedge clk);

        $display("[TB] request while busy is dropped");
        applyStimulus(8'hFF, 1'b0, 1'b0, 6'd8);
        fork
            measureFrame(8, 1'b0, busyCycles, dataByte, startBit, parBit, stopHigh);
            begin
                repeat (8) @(negedge clk);
                bus.p_data_i     = 8'h55;
                bus.data_valid_i = 1'b1;
                @(negedge clk);
                bus.data_valid_i = 1'b0;
            end
        join
        checkOutput("ffData", dataByte, 8'hFF);
        checkOutput("ffBusy", busyCycles, B8N1);
        cnt = 0;
        repeat (20) begin
            if (bus.busy_o !== 1'b0) cnt++;
            @(negedge clk);
        end
        checkOutput("ignoredReq", cnt, 0);

        $display("[TB] back-to-back frames");
        bus.p_data_i        = 8'h12;
        bus.parity_enable_i = 1'b0;
        bus.prescale_i      = 6'd8;
        bus.data_valid_i    = 1'b1;
        measureFrame(8, 1'b0, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("b2bFirst", dataByte, 8'h12);
        bus.p_data_i = 8'h34;
        gap = 0;
        while (bus.busy_o !== 1'b1 && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        bus.data_valid_i = 1'b0;
        checkOutput("b2bGap", gap, 1);
        measureFrame(8, 1'b0, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("b2bSecond", dataByte, 8'h34);
        repeat (3) @(negedge clk);

        $display("[TB] inputs change after acceptance");
        applyStimulus(8'hC3, 1'b0, 1'b0, 6'd4);
        bus.p_data_i   = 8'h00;
        bus.prescale_i = 6'd16;
        measureFrame(4, 1'b0, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("latchData", dataByte, 8'hC3);
        checkOutput("latchBusy", busyCycles, B4N1);
        repeat (3) @(negedge clk);

        $display("[TB] prescale 1 and 0");
        applyStimulus(8'h96, 1'b0, 1'b0, 6'd1);
        measureFrame(1, 1'b0, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("pre1Busy", busyCycles, B1N1);
        checkOutput("pre1Data", dataByte, 8'h96);
        repeat (2) @(negedge clk);
        applyStimulus(8'h69, 1'b0, 1'b0, 6'd0);
        measureFrame(0, 1'b0, busyCycles, dataByte, startBit, parBit, stopHigh);
        checkOutput("pre0Busy", busyCycles, B1N1);
        checkOutput("pre0Data", dataByte, 8'h69);
        repeat (3) @(negedge clk);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(8'h3C, 1'b0, 1'b0, 6'd8);
        repeat (41) @(negedge clk);
        checkOutput("preAbortBusy", bus.busy_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortTx", bus.tx_out_o, 1'b1);
        checkOutput("abortBusy", bus.busy_o, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.tx_out_o !== 1'b1 || bus.busy_o !== 1'b0) cnt++;
        end
        checkOutput("noResume", cnt, 0);

        cmpEn = 1'b0;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
